key_mux_lock: RTL and testbench

KEY_MUX_LOCK -- requirements
Module: key_mux_lock

---
 rtl/key_mux_lock.sv | 177 +++++++++++++++++
 tb/tb_key_mux_lock.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_mux_lock.sv
// key_mux_lock: bank of NCH keyed multiplexers. A serial key frame (KEYW
// bits LSB-first, then one even-parity bit) is shifted into a shadow
// register and committed to the active key only when the parity checks.
// Three consecutive bad frames lock the block until rst_n.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_start    single-cycle request to begin (or restart) a key frame
//   key_valid    key_bit is valid this cycle
//   key_bit      serial key / parity data
//   key_ready    block accepts key_bit this cycle (high exactly in LOAD)
//   mux_in       channel i, input j is bit i*NIN+j
//   mux_out      registered keyed selection, one bit per channel
//   active       a verified key is committed
//   error        the last frame failed parity
//   lockout      permanent lock until reset
//   fail_cnt     consecutive parity failures
module key_mux_lock #(
    parameter int unsigned NCH  = 10,
    parameter int unsigned SELW = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_start,
    input  logic                      key_valid,
    input  logic                      key_bit,
    output logic                      key_ready,
    input  logic [NCH*(2**SELW)-1:0]  mux_in,
    output logic [NCH-1:0]            mux_out,
    output logic                      active,
    output logic                      error,
    output logic                      lockout,
    output logic [1:0]                fail_cnt
);

    localparam int unsigned NIN  = 2**SELW;
    localparam int unsigned KEYW = NCH * SELW;
    localparam int unsigned CNTW = $clog2(KEYW + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        ACTIVE  = 3'd3,
        ERROR   = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [KEYW-1:0]   shadow, shadow_nxt;
    logic              parity_q, parity_nxt;
    logic [KEYW-1:0]   key_q, key_nxt;
    logic              active_nxt;
    logic [1:0]        fail_nxt;
    logic              key_ready_nxt;
    logic              error_nxt;
    logic              lockout_nxt;
    logic [NCH-1:0]    mux_nxt;
    logic [NIN-1:0]    chan;
    logic [SELW-1:0]   sel;
    logic              parity_ok;

    assign parity_ok = (parity_q == (^shadow));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and key datapath
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        parity_nxt = parity_q;
        key_nxt    = key_q;
        active_nxt = active;
        fail_nxt   = fail_cnt;

        case (state)
            IDLE, ACTIVE, ERROR: begin
                // From ACTIVE the committed key stays live through the reload
                if (key_start) begin
                    state_nxt  = LOAD;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end
            end
            LOAD: begin
                if (key_start) begin
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else if (key_valid && key_ready) begin
                    if (cnt == CNTW'(KEYW)) begin
                        parity_nxt = key_bit;
                        state_nxt  = CHECK;
                    end else begin
                        for (int unsigned b = 0; b < KEYW; b++) begin
                            if (cnt == CNTW'(b)) begin
                                shadow_nxt[b] = key_bit;
                            end
                        end
                        cnt_nxt = cnt + CNTW'(1);
                    end
                end
            end
            CHECK: begin
                if (parity_ok) begin
                    key_nxt    = shadow;
                    active_nxt = 1'b1;
                    fail_nxt   = 2'd0;
                    state_nxt  = ACTIVE;
                end else begin
                    key_nxt    = '0;
                    active_nxt = 1'b0;
                    fail_nxt   = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
                    state_nxt  = (fail_cnt >= 2'd2) ? LOCKOUT : ERROR;
                end
            end
            LOCKOUT: begin
                fail_nxt = 2'd3;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered-output next values; mux uses the post-edge key so the
    // first keyed sample lands on the cycle after a CHECK pass
    always_comb begin
        key_ready_nxt = (state_nxt == LOAD);
        error_nxt     = (state_nxt == ERROR);
        lockout_nxt   = (state_nxt == LOCKOUT);
        mux_nxt       = '0;
        chan          = '0;
        sel           = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            chan       = mux_in[i*NIN +: NIN];
            sel        = key_nxt[i*SELW +: SELW];
            mux_nxt[i] = active_nxt & chan[sel];
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shadow    <= '0;
            parity_q  <= 1'b0;
            key_q     <= '0;
            active    <= 1'b0;
            fail_cnt  <= 2'd0;
            key_ready <= 1'b0;
            error     <= 1'b0;
            lockout   <= 1'b0;
            mux_out   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            parity_q  <= parity_nxt;
            key_q     <= key_nxt;
            active    <= active_nxt;
            fail_cnt  <= fail_nxt;
            key_ready <= key_ready_nxt;
            error     <= error_nxt;
            lockout   <= lockout_nxt;
            mux_out   <= mux_nxt;
        end
    end

endmodule

// File: tb/tb_key_mux_lock.sv
// Bench for key_mux_lock: a queue-based frame model predicts every output
// each cycle; literal pins anchor the model at key scenarios.
module tb_key_mux_lock;

    localparam int NCH  = 10;
    localparam int SELW = 2;
    localparam int NIN  = 4;
    localparam int KEYW = NCH * SELW;
    localparam int MUXW = NCH * NIN;

    localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_ACTIVE = 3, M_ERROR = 4, M_LOCK = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_start = 1'b0;
    logic            key_valid = 1'b0;
    logic            key_bit = 1'b0;
    logic            key_ready;
    logic [MUXW-1:0] mux_in = '0;
    logic [NCH-1:0]  mux_out;
    logic            active;
    logic            error;
    logic            lockout;
    logic [1:0]      fail_cnt;

    bit              pat_mode = 1'b0;

    key_mux_lock #(.NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_start (key_start),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_ready (key_ready),
        .mux_in    (mux_in),
        .mux_out   (mux_out),
        .active    (active),
        .error     (error),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Data inputs: fixed pattern (bit i*4+1 set) or random each cycle
    always @(negedge clk) begin
        if (pat_mode) mux_in = 40'h22_2222_2222;
        else          mux_in = {8'($urandom), $urandom};
    end

    // ---------------- behavioural model ----------------
    int              m_mode = M_IDLE;
    bit              m_q[$];
    logic [KEYW-1:0] m_key = '0;
    bit              m_live = 1'b0;
    int              m_fail = 0;
    logic [NCH-1:0]  m_mux = '0;

    int n_tests = 0;
    int n_fail  = 0;

    string           pin_name = "";
    bit              pin_act, pin_err, pin_lock, pin_rdy, pin_mux_en;
    int              pin_fc;
    logic [NCH-1:0]  pin_mux;
    int              pin_id = 0;
    int              pin_seen = 0;

    function automatic logic [NCH-1:0] model_mux(logic [KEYW-1:0] k, bit live, logic [MUXW-1:0] mx);
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            int s;
            s = int'((k >> (i * SELW)) & 20'd3);
            r[i] = live & mx[i * NIN + s];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_key  = '0;
        m_live = 1'b0;
        m_fail = 0;
        m_mux  = '0;
    endtask

    task automatic model_step();
        bit xs;
        logic [KEYW-1:0] k;
        case (m_mode)
            M_IDLE, M_ACTIVE, M_ERROR: begin
                if (key_start) begin
                    m_mode = M_LOAD;
                    m_q.delete();
                end
            end
            M_LOAD: begin
                if (key_start) m_q.delete();
                else if (key_valid) begin
                    m_q.push_back(key_bit);
                    if (m_q.size() == KEYW + 1) m_mode = M_CHECK;
                end
            end
            M_CHECK: begin
                xs = 1'b0;
                k  = '0;
                for (int b = 0; b < KEYW; b++) begin
                    xs   ^= m_q[b];
                    k[b]  = m_q[b];
                end
                if (m_q[KEYW] == xs) begin
                    m_key  = k;
                    m_live = 1'b1;
                    m_fail = 0;
                    m_mode = M_ACTIVE;
                end else begin
                    m_key  = '0;
                    m_live = 1'b0;
                    m_fail = (m_fail < 3) ? m_fail + 1 : 3;
                    m_mode = (m_fail == 3) ? M_LOCK : M_ERROR;
                end
            end
            default: ;
        endcase
        m_mux = model_mux(m_key, m_live, mux_in);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Single compare process: model vs DUT every clock and on async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("key_ready", 64'(key_ready), 64'(m_mode == M_LOAD));
        check("active",    64'(active),    64'(m_live));
        check("error",     64'(error),     64'(m_mode == M_ERROR));
        check("lockout",   64'(lockout),   64'(m_mode == M_LOCK));
        check("fail_cnt",  64'(fail_cnt),  64'(m_fail));
        check("mux_out",   64'(mux_out),   64'(m_mux));
        if (pin_id != pin_seen) begin
            pin_seen = pin_id;
            check({pin_name, ".active"},    64'(active),   64'(pin_act));
            check({pin_name, ".error"},     64'(error),    64'(pin_err));
            check({pin_name, ".lockout"},   64'(lockout),  64'(pin_lock));
            check({pin_name, ".fail_cnt"},  64'(fail_cnt), 64'(pin_fc));
            check({pin_name, ".key_ready"}, 64'(key_ready), 64'(pin_rdy));
            check({pin_name, ".model_fail"}, 64'(m_fail),  64'(pin_fc));
            check({pin_name, ".model_live"}, 64'(m_live),  64'(pin_act));
            if (pin_mux_en) begin
                check({pin_name, ".mux_out"},   64'(mux_out), 64'(pin_mux));
                check({pin_name, ".model_mux"}, 64'(m_mux),   64'(pin_mux));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pin(string nm, bit a, bit e, bit l, int fc, bit r, bit me, logic [NCH-1:0] mx);
        pin_name   = nm;
        pin_act    = a;
        pin_err    = e;
        pin_lock   = l;
        pin_fc     = fc;
        pin_rdy    = r;
        pin_mux_en = me;
        pin_mux    = mx;
        pin_id++;
    endtask

    task automatic tick();
        @(negedge clk);
        key_start = 1'b0;
        key_valid = 1'b0;
        key_bit   = 1'($urandom);
    endtask

    // key_start pulse, then nbits accepted bits with 0..maxgap idle cycles
    // before each; returns at the negedge after the last bit
    task automatic send_bits(logic [KEYW-1:0] k, bit par, int nbits, int maxgap, bit ks_noise);
        key_start = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        key_start = 1'b0;
        for (int n = 0; n < nbits; n++) begin
            repeat ($urandom_range(0, maxgap)) begin
                key_valid = 1'b0;
                key_bit   = 1'($urandom);
                @(negedge clk);
            end
            key_valid = 1'b1;
            key_bit   = (n < KEYW) ? k[n] : par;
            @(negedge clk);
        end
        key_valid = 1'b0;
        key_start = ks_noise;
    endtask

    task automatic send_frame(logic [KEYW-1:0] k, bit par, int maxgap);
        send_bits(k, par, KEYW + 1, maxgap, 1'b0);
    endtask

    task automatic async_reset(string nm);
        key_start = 1'b0;
        key_valid = 1'b0;
        set_pin(nm, 0, 0, 0, 0, 0, 1, '0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [KEYW-1:0] k;
        bit par;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Good key, sel=1 on every channel
        pat_mode = 1'b1;
        tick();
        send_frame(20'h55555, 1'b0, 0);
        set_pin("good_key", 1, 0, 0, 0, 0, 1, 10'h3FF);
        repeat (3) tick();

        // Parity fail
        send_frame(20'h55555, 1'b1, 0);
        set_pin("parity_fail", 0, 1, 0, 1, 0, 1, '0);
        repeat (2) tick();

        // Two more bad frames -> lockout; a good frame is then ignored
        send_frame(20'h55555, 1'b1, 1);
        tick();
        send_frame(20'h12345, ~(^20'h12345), 1);
        set_pin("lockout", 0, 0, 1, 3, 0, 1, '0);
        tick();
        send_frame(20'h55555, 1'b0, 0);
        set_pin("lock_hold", 0, 0, 1, 3, 0, 1, '0);
        tick();
        async_reset("reset_lock");

        // Reload from ACTIVE: old key drives mux until CHECK
        pat_mode = 1'b0;
        tick();
        send_frame(20'h55555, 1'b0, 0);
        tick();
        tick();
        send_frame(20'h00000, 1'b0, 2);
        set_pin("reload", 1, 0, 0, 0, 0, 0, '0);
        repeat (2) tick();

        // fail_cnt 2 -> 0 by a good frame
        send_frame(20'h0000F, 1'b1, 1);
        tick();
        send_frame(20'h0000F, 1'b1, 1);
        set_pin("fail_two", 0, 1, 0, 2, 0, 1, '0);
        tick();
        send_frame(20'h0000F, 1'b0, 1);
        set_pin("fail_clear", 1, 0, 0, 0, 0, 0, '0);
        repeat (2) tick();

        // Abort after 7 bits, then identical key with gaps 0 and 3
        pat_mode = 1'b1;
        send_bits(20'hFFFFF, 1'b0, 7, 1, 1'b0);
        send_frame(20'h55555, 1'b0, 0);
        set_pin("abort_gap0", 1, 0, 0, 0, 0, 1, 10'h3FF);
        tick();
        send_bits(20'hFFFFF, 1'b0, 7, 2, 1'b0);
        send_frame(20'h55555, 1'b0, 3);
        set_pin("abort_gap3", 1, 0, 0, 0, 0, 1, 10'h3FF);
        tick();

        // Async reset mid-LOAD and in ACTIVE
        send_bits(20'hABCDE, 1'b0, 5, 0, 1'b0);
        async_reset("async_load");
        tick();
        send_frame(20'h55555, 1'b0, 0);
        repeat (2) tick();
        async_reset("async_active");
        pat_mode = 1'b0;

        // Randomized frames
        for (int it = 0; it < 80; it++) begin
            k   = 20'($urandom);
            par = ($urandom_range(0, 3) != 0) ? ^k : ~(^k);
            if ($urandom_range(0, 7) == 0)
                send_bits(20'($urandom), 1'($urandom), $urandom_range(0, KEYW), 2, 1'b0);
            send_bits(k, par, KEYW + 1, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(1, 3)) begin
                tick();
                key_valid = 1'($urandom);
            end
            tick();
            if (m_mode == M_LOCK && $urandom_range(0, 1) == 0) async_reset("rand_unlock");
            else if ($urandom_range(0, 15) == 0) async_reset("rand_reset");
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
